aes_key_sched_ctrl: RTL

Controller that owns the AES key expansion engine. It accepts a key-load command, sequences the engine (En/Start), captures every expanded word into a 60x32 round-key store, and validates the word count on completion. It then serves 128-bit round keys to two requesters (encrypt core = port 0, decrypt core = port 1) through a round-robin arbiter with a one-cycle registered read.

---
 rtl/aes_key_sched_ctrl_if.sv | 21 ++
 rtl/aes_key_sched_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// Round-key request/response bus between the key schedule controller and
// its two requesters (encrypt core on port 0, decrypt core on port 1).
interface aes_key_sched_ctrl_if;
  logic [1:0]   ReqValid;
  logic [7:0]   ReqRound;
  logic [1:0]   ReqReady;
  logic         RspValid;
  logic         RspId;
  logic [127:0] RspData;
  logic         RspErr;

  modport master (
    output ReqValid, ReqRound,
    input  ReqReady, RspValid, RspId, RspData, RspErr
  );

  modport slave (
    input  ReqValid, ReqRound,
    output ReqReady, RspValid, RspId, RspData, RspErr
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES key schedule controller: drives the expansion engine, captures the
// expanded words into a 60x32 store and serves round keys to two requesters.
module aes_key_sched_ctrl #(
  parameter int TIMEOUT = 100,
  parameter int NREQ    = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         KeyLoadValid,
  output logic         KeyLoadReady,
  input  logic [1:0]   KeyLen,
  input  logic [255:0] KeyIn,
  output logic         KeyReady,
  output logic         KeyErr,
  output logic [3:0]   Nr,
  output logic         ExpEn,
  output logic         ExpStart,
  output logic [1:0]   ExpKeyLen,
  output logic [255:0] ExpKeyIn,
  input  logic [31:0]  ExpWord,
  input  logic [5:0]   ExpWordIndex,
  input  logic         ExpValid,
  input  logic         ExpDone,
  aes_key_sched_ctrl_if.slave rk_bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, EXPAND, READY, ERR} state_t;

  state_t          state, state_next;
  logic [31:0]     store [60];
  logic [3:0]      nr_target;
  logic [5:0]      total_words;
  logic [6:0]      word_cnt, cnt_now;
  logic [TW-1:0]   timer;
  logic            idx_err, err_now;
  logic            key_ready, key_err;
  logic [3:0]      nr;
  logic            last_grant;
  logic            load_acc, word_in, idx_bad, done_ok;
  logic [NREQ-1:0] grant;
  logic [3:0]      gnt_round;
  logic            rd_err;
  logic [5:0]      rd_base;
  logic [127:0]    rd_data;
  logic            rsp_valid, rsp_id, rsp_err;
  logic [127:0]    rsp_data;

  assign KeyLoadReady = (state == IDLE) || (state == READY) || (state == ERR);
  assign load_acc     = KeyLoadValid && KeyLoadReady;
  assign ExpEn        = (state == START) || (state == EXPAND);
  assign ExpStart     = (state == START);
  assign KeyReady     = key_ready;
  assign KeyErr       = key_err;
  assign Nr           = nr;

  // A word arriving together with ExpDone still counts toward completion.
  assign word_in = (state == EXPAND) && ExpValid;
  assign idx_bad = ExpWordIndex > 6'd59;
  assign cnt_now = word_cnt + {6'd0, word_in};
  assign err_now = idx_err | (word_in & idx_bad);
  assign done_ok = (cnt_now == {1'b0, total_words}) && !err_now;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, READY, ERR: if (load_acc) state_next = START;
      START:            state_next = EXPAND;
      EXPAND: begin
        if (ExpDone)                          state_next = done_ok ? READY : ERR;
        else if (timer == TW'(TIMEOUT - 1))   state_next = ERR;
      end
      default:          state_next = IDLE;
    endcase
  end

  // Round-robin grant; a pending load in READY blocks all reads that cycle.
  always_comb begin
    grant = '0;
    if (state == READY && !KeyLoadValid) begin
      if (rk_bus.ReqValid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else                          grant = rk_bus.ReqValid;
    end
  end

  assign rk_bus.ReqReady = grant;
  assign gnt_round = grant[1] ? rk_bus.ReqRound[7:4] : rk_bus.ReqRound[3:0];
  assign rd_err    = gnt_round > nr;
  assign rd_base   = rd_err ? 6'd0 : {gnt_round, 2'b00};
  assign rd_data   = {store[rd_base], store[rd_base + 6'd1],
                      store[rd_base + 6'd2], store[rd_base + 6'd3]};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      ExpKeyLen   <= '0;
      ExpKeyIn    <= '0;
      nr_target   <= '0;
      total_words <= '0;
      word_cnt    <= '0;
      timer       <= '0;
      idx_err     <= 1'b0;
      key_ready   <= 1'b0;
      key_err     <= 1'b0;
      nr          <= '0;
      last_grant  <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state <= state_next;
      if (load_acc) begin
        ExpKeyLen  <= KeyLen;
        ExpKeyIn   <= KeyIn;
        case (KeyLen)
          2'b01:   begin nr_target <= 4'd12; total_words <= 6'd52; end
          2'b10:   begin nr_target <= 4'd14; total_words <= 6'd60; end
          default: begin nr_target <= 4'd10; total_words <= 6'd44; end
        endcase
        key_ready  <= 1'b0;
        key_err    <= 1'b0;
        nr         <= '0;
        word_cnt   <= '0;
        timer      <= '0;
        idx_err    <= 1'b0;
        last_grant <= 1'b1;
      end else if (state == EXPAND) begin
        timer    <= timer + TW'(1);
        word_cnt <= cnt_now;
        idx_err  <= err_now;
        if (state_next == READY) begin
          key_ready <= 1'b1;
          nr        <= nr_target;
        end else if (state_next == ERR) begin
          key_err <= 1'b1;
        end
      end
      if (|grant) last_grant <= grant[1];
      rsp_valid <= |grant;
      if (|grant) begin
        rsp_id   <= grant[1];
        rsp_data <= rd_err ? '0 : rd_data;
        rsp_err  <= rd_err;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (word_in && !idx_bad) store[ExpWordIndex] <= ExpWord;
  end

  assign rk_bus.RspValid = rsp_valid;
  assign rk_bus.RspId    = rsp_id;
  assign rk_bus.RspData  = rsp_data;
  assign rk_bus.RspErr   = rsp_err;

endmodule
